dpram_be_clr: RTL

Parametrised true dual-port synchronous RAM with per-lane byte enables, selectable same-port read-during-write behaviour, deterministic cross-port collision resolution and a built-in sequential clear engine that fills the array with a constant after reset or on request. It is the general-purpose successor to the single-port RAM: it serves as a CPU/video shared work RAM, a tile or sprite buffer, or any store that needs two independent ports and a known power-up content.

---
 rtl/dpram_be_clr.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/dpram_be_clr.sv
// dpram_be_clr: true dual-port synchronous RAM with per-lane byte enables,
// selectable same-port read-during-write, port-A-wins collision resolution
// and a sequential clear engine that fills the array after reset or on request.
// Optional build macro: DPRAM_OUTREG_EN adds a second output register stage
// on q_a, q_b and collision (read latency 2 instead of 1).
module dpram_be_clr #(
  parameter int data_width = 8,
  parameter int address_width = 8,
  parameter int byte_width = 8,
  parameter int rdw_new = 1,
  parameter logic [data_width-1:0] clear_value = '0
) (
  input  logic                               clock,
  input  logic                               reset_n,
  input  logic                               clear,
  output logic                               busy,
  input  logic [address_width-1:0]           addr_a,
  input  logic [address_width-1:0]           addr_b,
  input  logic [data_width-1:0]              data_a,
  input  logic [data_width-1:0]              data_b,
  input  logic                               we_a,
  input  logic                               we_b,
  input  logic [data_width/byte_width-1:0]   be_a,
  input  logic [data_width/byte_width-1:0]   be_b,
  output logic [data_width-1:0]              q_a,
  output logic [data_width-1:0]              q_b,
  output logic                               collision
);

  localparam int lanes = data_width / byte_width;
  localparam int depth = 2 ** address_width;
  localparam logic [address_width:0] last_addr = {1'b0, {address_width{1'b1}}};

  typedef enum logic {
    S_CLEAR,
    S_IDLE
  } state_t;

  state_t state, state_next;

  // One extra counter bit so the final compare never aliases address 0.
  logic [address_width:0]   count, count_next;
  logic [address_width-1:0] clear_addr;

  logic [data_width-1:0] old_a, old_b;
  logic [data_width-1:0] merged_a, merged_b;
  logic [data_width-1:0] read_a, read_b;
  logic                  overlap;

  logic [data_width-1:0] q1_a, q1_b;
  logic                  coll1;

  assign busy       = (state == S_CLEAR);
  assign clear_addr = count[address_width-1:0];

  // Clear engine state and address counter; reset restarts a full clear.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_CLEAR;
      count <= '0;
    end else begin
      state <= state_next;
      count <= count_next;
    end
  end

  // Clear engine sequencing: sweep every address once, then wait for a request.
  always_comb begin
    state_next = state;
    count_next = count;
    case (state)
      S_CLEAR: begin
        count_next = count + 1'b1;
        if (count == last_addr) begin
          state_next = S_IDLE;
        end
      end
      S_IDLE: begin
        if (clear) begin
          state_next = S_CLEAR;
          count_next = '0;
        end
      end
      default: begin
        state_next = S_CLEAR;
        count_next = '0;
      end
    endcase
  end

  // Storage is split per byte lane so each lane has its own write enable.
  for (genvar g = 0; g < lanes; g++) begin : g_lane
    logic [byte_width-1:0] store [depth];

    // Lane write: clear engine owns the array while busy; otherwise port B
    // writes first and port A's later assignment wins on a shared address.
    always_ff @(posedge clock) begin
      if (busy) begin
        if (reset_n) begin
          store[clear_addr] <= clear_value[g*byte_width +: byte_width];
        end
      end else begin
        if (we_b && be_b[g]) begin
          store[addr_b] <= data_b[g*byte_width +: byte_width];
        end
        if (we_a && be_a[g]) begin
          store[addr_a] <= data_a[g*byte_width +: byte_width];
        end
      end
    end

    assign old_a[g*byte_width +: byte_width] = store[addr_a];
    assign old_b[g*byte_width +: byte_width] = store[addr_b];
  end

  // Read data selection: pre-write word or own-port merged word, plus the
  // overlapping-lane collision flag.
  always_comb begin
    merged_a = old_a;
    merged_b = old_b;
    for (int i = 0; i < lanes; i++) begin
      if (be_a[i]) begin
        merged_a[i*byte_width +: byte_width] = data_a[i*byte_width +: byte_width];
      end
      if (be_b[i]) begin
        merged_b[i*byte_width +: byte_width] = data_b[i*byte_width +: byte_width];
      end
    end
    read_a  = ((rdw_new != 0) && we_a) ? merged_a : old_a;
    read_b  = ((rdw_new != 0) && we_b) ? merged_b : old_b;
    overlap = we_a && we_b && (addr_a == addr_b) && (|(be_a & be_b));
  end

  // First output stage: registered read data, forced to zero while clearing.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      q1_a  <= '0;
      q1_b  <= '0;
      coll1 <= 1'b0;
    end else if (busy) begin
      q1_a  <= '0;
      q1_b  <= '0;
      coll1 <= 1'b0;
    end else begin
      q1_a  <= read_a;
      q1_b  <= read_b;
      coll1 <= overlap;
    end
  end

`ifdef DPRAM_OUTREG_EN
  logic [data_width-1:0] q2_a, q2_b;
  logic                  coll2;

  // Second output stage for timing closure; also zero while clearing.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      q2_a  <= '0;
      q2_b  <= '0;
      coll2 <= 1'b0;
    end else if (busy) begin
      q2_a  <= '0;
      q2_b  <= '0;
      coll2 <= 1'b0;
    end else begin
      q2_a  <= q1_a;
      q2_b  <= q1_b;
      coll2 <= coll1;
    end
  end

  assign q_a       = q2_a;
  assign q_b       = q2_b;
  assign collision = coll2;
`else
  assign q_a       = q1_a;
  assign q_b       = q1_b;
  assign collision = coll1;
`endif

endmodule
